// File: rtl/qpi_bus_arbiter.sv
// rtl/qpi_bus_arbiter.sv - quad-SPI pad arbiter between flash controller (F) and accelerator host (M).
// Optional hold timeout with yield/forced revoke is enabled by defining QPI_ARB_TIMEOUT_EN.
module qpi_bus_arbiter #(
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned MAX_HOLD    = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       f_req,
  input  logic       m_req,
  output logic       f_gnt,
  output logic       m_gnt,
  output logic       f_yield,
  output logic       m_yield,
  input  logic       f_csb,
  input  logic       f_clk,
  input  logic       m_csb,
  input  logic       m_clk,
  input  logic [3:0] f_oe,
  input  logic [3:0] f_do,
  input  logic [3:0] m_oe,
  input  logic [3:0] m_do,
  input  logic [3:0] io_di,
  output logic [3:0] f_di,
  output logic [3:0] m_di,
  output logic       flash_csb,
  output logic       flash_clk,
  output logic       ml_csb,
  output logic       ml_clk,
  output logic [3:0] io_oe,
  output logic [3:0] io_do,
  output logic       proto_err
);

  typedef enum logic [1:0] {IDLE, GNT_F, GNT_M, TURN} state_e;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

  state_e     state_q;
  logic       last_m_q;
  logic [3:0] turn_q;
  logic       f_gnt_q;
  logic       m_gnt_q;
  logic       err_q;
  logic       own_req;
  logic       own_csb;
  logic       oe_viol;
  logic       revoke;

  assign own_req = (state_q == GNT_F) ? f_req : m_req;
  assign own_csb = (state_q == GNT_F) ? f_csb : m_csb;
  assign oe_viol = ((f_oe != 4'd0) && (state_q != GNT_F)) ||
                   ((m_oe != 4'd0) && (state_q != GNT_M));

`ifdef QPI_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_YIELD  = 16'(MAX_HOLD);
  localparam logic [15:0] HOLD_REVOKE = 16'(2 * MAX_HOLD);

  logic [15:0] hold_q;
  logic [15:0] hold_inc;
  logic        f_yield_q;
  logic        m_yield_q;
  logic        granted;
  logic        oth_req;

  assign granted  = (state_q == GNT_F) || (state_q == GNT_M);
  assign oth_req  = (state_q == GNT_F) ? m_req : f_req;
  assign hold_inc = hold_q + 16'd1;
  assign revoke   = granted && own_req && oth_req && (hold_inc == HOLD_REVOKE);

  // Counter only advances while the other side is waiting; any exit from GNT clears it.
  always_ff @(posedge clk) begin
    if (reset || !granted || !own_req || revoke) begin
      hold_q    <= '0;
      f_yield_q <= 1'b0;
      m_yield_q <= 1'b0;
    end else if (oth_req) begin
      hold_q <= hold_inc;
      if (hold_inc == HOLD_YIELD) begin
        f_yield_q <= (state_q == GNT_F);
        m_yield_q <= (state_q == GNT_M);
      end
    end
  end

  assign f_yield = f_yield_q;
  assign m_yield = m_yield_q;
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = ^(16'(MAX_HOLD));
  assign revoke  = 1'b0;
  assign f_yield = 1'b0;
  assign m_yield = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_m_q <= 1'b1;
      turn_q   <= '0;
      f_gnt_q  <= 1'b0;
      m_gnt_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (oe_viol) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (f_req && (!m_req || last_m_q)) begin
            state_q <= GNT_F;
            f_gnt_q <= 1'b1;
          end else if (m_req) begin
            state_q <= GNT_M;
            m_gnt_q <= 1'b1;
          end
        end
        GNT_F, GNT_M: begin
          if (!own_req || revoke) begin
            state_q  <= TURN;
            f_gnt_q  <= 1'b0;
            m_gnt_q  <= 1'b0;
            last_m_q <= (state_q == GNT_M);
            turn_q   <= TURN_LOAD;
            // Releasing with CSB still low aborts a live transaction.
            if (revoke || !own_csb) err_q <= 1'b1;
          end
        end
        TURN: begin
          if (turn_q == 4'd0) state_q <= IDLE;
          else                turn_q  <= turn_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    io_oe     = 4'd0;
    io_do     = 4'd0;
    flash_csb = 1'b1;
    flash_clk = 1'b0;
    ml_csb    = 1'b1;
    ml_clk    = 1'b0;
    case (state_q)
      GNT_F: begin
        io_oe     = f_oe;
        io_do     = f_do;
        flash_csb = f_csb;
        flash_clk = f_clk;
      end
      GNT_M: begin
        io_oe  = m_oe;
        io_do  = m_do;
        ml_csb = m_csb;
        ml_clk = m_clk;
      end
      default: ;
    endcase
  end

  assign f_gnt     = f_gnt_q;
  assign m_gnt     = m_gnt_q;
  assign proto_err = err_q;
  assign f_di      = io_di;
  assign m_di      = io_di;

endmodule

// File: tb/tb_qpi_bus_arbiter.sv
// tb/tb_qpi_bus_arbiter.sv - self-checking bench for qpi_bus_arbiter (timeout feature disabled).
module tb_qpi_bus_arbiter;

  localparam int TURN = 2;
  localparam int HOLD = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic       req [2];
  logic       csb [2];
  logic       sck [2];
  logic [3:0] oe  [2];
  logic [3:0] dout[2];
  logic [3:0] io_di;
  logic       f_gnt, m_gnt, f_yield, m_yield;
  logic [3:0] f_di, m_di, io_oe, io_do;
  logic       flash_csb, flash_clk, ml_csb, ml_clk, proto_err;

  always #5 clk = ~clk;

  qpi_bus_arbiter #(.TURN_CYCLES(TURN), .MAX_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset),
    .f_req(req[0]), .m_req(req[1]),
    .f_gnt(f_gnt), .m_gnt(m_gnt), .f_yield(f_yield), .m_yield(m_yield),
    .f_csb(csb[0]), .f_clk(sck[0]), .m_csb(csb[1]), .m_clk(sck[1]),
    .f_oe(oe[0]), .f_do(dout[0]), .m_oe(oe[1]), .m_do(dout[1]),
    .io_di(io_di), .f_di(f_di), .m_di(m_di),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .ml_csb(ml_csb), .ml_clk(ml_clk),
    .io_oe(io_oe), .io_do(io_do), .proto_err(proto_err)
  );

  // Reference model: owner 0=none 1=F 2=M; a new grant may only be decided
  // TURN+1 edges after the edge that sampled the release.
  int owner, last, rel_edge, edge_n;
  bit err_m;
  int n_chk = 0;
  int n_fail = 0;
  int rem[2];
  int lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      owner = 0; last = 2; rel_edge = -100; err_m = 1'b0;
    end else begin
      if (oe[0] != 4'd0 && owner != 1) err_m = 1'b1;
      if (oe[1] != 4'd0 && owner != 2) err_m = 1'b1;
      if (owner != 0) begin
        if (!req[owner-1]) begin
          if (!csb[owner-1]) err_m = 1'b1;
          last = owner; owner = 0; rel_edge = edge_n;
        end
      end else if (edge_n >= rel_edge + TURN + 1) begin
        if (req[0] && req[1]) owner = (last == 1) ? 2 : 1;
        else if (req[0])      owner = 1;
        else if (req[1])      owner = 2;
      end
    end
    edge_n++;
  endtask

  task automatic check_all();
    logic [3:0] e_oe, e_do;
    logic [1:0] e_fl, e_ml;
    e_oe = (owner == 1) ? oe[0]   : (owner == 2) ? oe[1]   : 4'd0;
    e_do = (owner == 1) ? dout[0] : (owner == 2) ? dout[1] : 4'd0;
    e_fl = (owner == 1) ? {csb[0], sck[0]} : 2'b10;
    e_ml = (owner == 2) ? {csb[1], sck[1]} : 2'b10;
    chk("gnt",   {f_gnt, m_gnt}, {owner == 1, owner == 2});
    chk("pads",  {io_oe, io_do}, {e_oe, e_do});
    chk("dev",   {flash_csb, flash_clk, ml_csb, ml_clk}, {e_fl, e_ml});
    chk("di",    {f_di, m_di}, {io_di, io_di});
    chk("err",   proto_err, err_m);
    chk("yield", {f_yield, m_yield}, 2'b00);
  endtask

  // Called at a negedge with inputs already set; ends at the following negedge.
  task automatic step();
    io_di = 4'($urandom);
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; csb[i] = 1'b1; sck[i] = 1'b0; oe[i] = 4'd0; dout[i] = 4'd0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    io_di = 4'd0;
    edge_n = 0;
    reset = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    reset = 1'b0;

    chk("rst_gnt",  {f_gnt, m_gnt, f_yield, m_yield}, 4'b0000);
    chk("rst_dev",  {flash_csb, flash_clk, ml_csb, ml_clk}, 4'b1010);
    chk("rst_pads", {io_oe, io_do, proto_err}, 9'd0);

    // Simultaneous request: F wins first tie, M follows TURN+1 edges after release.
    req[0] = 1'b1; req[1] = 1'b1;
    step();
    chk("tie_f_first", {f_gnt, m_gnt}, 2'b10);
    for (int k = 0; k < 3; k++) begin
      csb[0] = 1'b0; sck[0] = k[0]; oe[0] = 4'hF; dout[0] = 4'(k + 5);
      step();
    end
    csb[0] = 1'b1; sck[0] = 1'b0; oe[0] = 4'd0;
    step();
    req[0] = 1'b0;
    step();
    chk("release_gnt", {f_gnt, m_gnt}, 2'b00);
    lat = 0;
    while (!m_gnt && lat < 20) begin
      step();
      lat++;
    end
    chk("turn_latency", lat, TURN + 1);

    // Isolation: non-owner F drives its pins while M owns the bus.
    csb[1] = 1'b0; oe[1] = 4'hF; dout[1] = 4'hA; oe[0] = 4'hF;
    #1;
    chk("iso_pads", {io_oe, io_do, flash_csb}, {4'hF, 4'hA, 1'b1});
    step();
    chk("iso_err", proto_err, 1'b1);
    set_idle();
    do_reset();
    chk("err_cleared", proto_err, 1'b0);

    // Early release with CSB still low.
    req[0] = 1'b1;
    step();
    csb[0] = 1'b0; oe[0] = 4'h3;
    step();
    req[0] = 1'b0; oe[0] = 4'd0;
    step();
    chk("early_err",  proto_err, 1'b1);
    chk("early_turn", {f_gnt, io_oe, flash_csb}, {1'b0, 4'd0, 1'b1});
    set_idle();
    step();

    // Reset mid-grant with F in a live transaction.
    do_reset();
    req[0] = 1'b1;
    step();
    csb[0] = 1'b0; sck[0] = 1'b1; oe[0] = 4'hF; dout[0] = 4'h6;
    step();
    chk("pre_rst_own", {f_gnt, flash_csb, io_oe}, {1'b1, 1'b0, 4'hF});
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst", {f_gnt, m_gnt, flash_csb, flash_clk, io_oe, io_do, proto_err},
        {2'b00, 2'b10, 4'd0, 4'd0, 1'b0});
    set_idle();
    step();

    // Without the timeout feature F holds indefinitely while M waits.
    req[0] = 1'b1;
    step();
    req[1] = 1'b1; csb[0] = 1'b0; oe[0] = 4'h1;
    for (int k = 0; k < 2 * HOLD + 40; k++) step();
    chk("no_revoke", {f_gnt, m_gnt, f_yield, proto_err}, 4'b1000);
    csb[0] = 1'b1; oe[0] = 4'd0; req[0] = 1'b0;
    for (int k = 0; k < TURN + 2; k++) step();
    chk("m_after_hold", {f_gnt, m_gnt}, 2'b01);
    set_idle();
    step();
    do_reset();

    // Randomized well-behaved traffic against the model.
    for (int i = 0; i < 2; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i]) begin
          csb[i] = 1'b1; sck[i] = 1'b0; oe[i] = 4'd0;
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            rem[i] = $urandom_range(12, 1);
          end
        end else if (owner == i + 1) begin
          if (rem[i] == 0) begin
            req[i] = 1'b0; csb[i] = 1'b1; sck[i] = 1'b0; oe[i] = 4'd0;
          end else begin
            rem[i]--;
            csb[i] = 1'b0; sck[i] = 1'($urandom);
            oe[i] = 4'($urandom); dout[i] = 4'($urandom);
          end
        end else begin
          csb[i] = 1'b1; sck[i] = 1'b0; oe[i] = 4'd0;
          if ($urandom_range(15) == 0) req[i] = 1'b0;
        end
      end
      step();
    end
    chk("random_no_err", proto_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
